stereo_frame_sequencer: RTL and testbench

- Sits between the USB byte FIFO and the I2S transmitter.
- Pops bytes from the FIFO and assembles them into little-endian samples, using the run-time sample-size code. Left channel first, then right.
- Presents each completed, masked stereo frame to the I2S transmitter over a valid/ready handshake, through a one-entry holding register.
- Reports underruns and illegal size codes.

---
 rtl/stereo_frame_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_stereo_frame_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_frame_sequencer.sv
// stereo_frame_sequencer
// Pulls bytes from a first-word-fall-through USB byte FIFO, assembles them
// into little-endian left/right samples of a run-time selectable size and
// hands each completed, masked stereo frame to the I2S transmitter through a
// one-entry holding register with a valid/ready handshake.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   enable           run request, only looked at when a frame starts
//   sample_size      size code 0=8b 1=12b 3=16b 4=24b 5=32b, others illegal
//   rxf_n, data_in   FIFO byte present (active-low) and the byte itself
//   rd_n             FIFO pop strobe, active-low, combinational
//   left_sample,
//   right_sample     holding-register contents
//   frame_valid      holding register full
//   frame_ready      I2S transmitter takes the held frame
//   underrun         transmitter asked while nothing was held
//   underrun_count   saturating count of underrun cycles
//   cfg_error        the code latched for the current frame was illegal
//   busy             a frame is being fetched or waiting for the holding reg

module stereo_frame_sequencer #(
    parameter int UNDERRUN_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [3:0]            sample_size,
    input  logic                  rxf_n,
    input  logic [7:0]            data_in,
    output logic                  rd_n,
    output logic [31:0]           left_sample,
    output logic [31:0]           right_sample,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  underrun,
    output logic [UNDERRUN_W-1:0] underrun_count,
    output logic                  cfg_error,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_OUT
    } state_t;

    localparam logic [UNDERRUN_W-1:0] COUNT_ONE = 1;

    state_t                  state_q, state_d;
    logic [3:0]              cfgSize_q, cfgSize_d;
    logic                    cfgErr_q, cfgErr_d;
    logic [1:0]              byteIdx_q, byteIdx_d;
    logic                    chanR_q, chanR_d;
    logic [31:0]             leftAsm_q, leftAsm_d;
    logic [31:0]             rightAsm_q, rightAsm_d;
    logic [31:0]             leftHold_q, leftHold_d;
    logic [31:0]             rightHold_q, rightHold_d;
    logic                    valid_q, valid_d;
    logic [UNDERRUN_W-1:0]   urCount_q, urCount_d;

    logic        sizeLegal;
    logic [1:0]  lastIdx;
    logic [31:0] sampleMask;
    logic        pop;
    logic        load;
    logic        startFrame;

    // Illegal codes are replaced by the 16-bit code when latched, so the
    // decode below only ever sees legal values.
    always_comb begin
        sizeLegal = 1'b0;
        case (sample_size)
            4'd0, 4'd1, 4'd3, 4'd4, 4'd5: sizeLegal = 1'b1;
            default:                      sizeLegal = 1'b0;
        endcase
    end

    // Index of the last byte of a sample and the mask for the latched size.
    always_comb begin
        lastIdx    = 2'd1;
        sampleMask = 32'h0000_FFFF;
        case (cfgSize_q)
            4'd0: begin lastIdx = 2'd0; sampleMask = 32'h0000_00FF; end
            4'd1: begin lastIdx = 2'd1; sampleMask = 32'h0000_0FFF; end
            4'd4: begin lastIdx = 2'd2; sampleMask = 32'h00FF_FFFF; end
            4'd5: begin lastIdx = 2'd3; sampleMask = 32'hFFFF_FFFF; end
            default: begin lastIdx = 2'd1; sampleMask = 32'h0000_FFFF; end
        endcase
    end

    assign pop  = (state_q == FETCH) && !rxf_n;
    assign rd_n = !pop;
    assign busy = (state_q != IDLE);

    assign underrun = !rst && frame_ready && !valid_q && (busy || enable);

    // Next-state logic. A completed frame loads the holding register when it
    // is empty or being emptied on the same edge; the final R byte is merged
    // into rightAsm_d before the load so it reaches the register at once.
    always_comb begin
        state_d     = state_q;
        cfgSize_d   = cfgSize_q;
        cfgErr_d    = cfgErr_q;
        byteIdx_d   = byteIdx_q;
        chanR_d     = chanR_q;
        leftAsm_d   = leftAsm_q;
        rightAsm_d  = rightAsm_q;
        leftHold_d  = leftHold_q;
        rightHold_d = rightHold_q;
        load        = 1'b0;
        startFrame  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) startFrame = 1'b1;
            end
            FETCH: begin
                if (pop) begin
                    if (chanR_q) rightAsm_d[{byteIdx_q, 3'b000} +: 8] = data_in;
                    else         leftAsm_d[{byteIdx_q, 3'b000} +: 8]  = data_in;
                    if (byteIdx_q == lastIdx) begin
                        byteIdx_d = 2'd0;
                        if (!chanR_q)                     chanR_d = 1'b1;
                        else if (!valid_q || frame_ready) load    = 1'b1;
                        else                              state_d = WAIT_OUT;
                    end else begin
                        byteIdx_d = byteIdx_q + 2'd1;
                    end
                end
            end
            WAIT_OUT: begin
                if (valid_q && frame_ready) load = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            leftHold_d  = leftAsm_d & sampleMask;
            rightHold_d = rightAsm_d & sampleMask;
            state_d     = IDLE;
            if (enable) startFrame = 1'b1;
        end

        if (startFrame) begin
            state_d    = FETCH;
            cfgSize_d  = sizeLegal ? sample_size : 4'd3;
            cfgErr_d   = !sizeLegal;
            byteIdx_d  = 2'd0;
            chanR_d    = 1'b0;
            leftAsm_d  = 32'd0;
            rightAsm_d = 32'd0;
        end
    end

    // Holding register occupancy and the saturating underrun counter.
    always_comb begin
        valid_d = valid_q;
        if (load)             valid_d = 1'b1;
        else if (frame_ready) valid_d = 1'b0;

        urCount_d = urCount_q;
        if (underrun && (urCount_q != '1)) urCount_d = urCount_q + COUNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cfgSize_q   <= 4'd0;
            cfgErr_q    <= 1'b0;
            byteIdx_q   <= 2'd0;
            chanR_q     <= 1'b0;
            leftAsm_q   <= 32'd0;
            rightAsm_q  <= 32'd0;
            leftHold_q  <= 32'd0;
            rightHold_q <= 32'd0;
            valid_q     <= 1'b0;
            urCount_q   <= '0;
        end else begin
            state_q     <= state_d;
            cfgSize_q   <= cfgSize_d;
            cfgErr_q    <= cfgErr_d;
            byteIdx_q   <= byteIdx_d;
            chanR_q     <= chanR_d;
            leftAsm_q   <= leftAsm_d;
            rightAsm_q  <= rightAsm_d;
            leftHold_q  <= leftHold_d;
            rightHold_q <= rightHold_d;
            valid_q     <= valid_d;
            urCount_q   <= urCount_d;
        end
    end

    assign left_sample    = leftHold_q;
    assign right_sample   = rightHold_q;
    assign frame_valid    = valid_q;
    assign underrun_count = urCount_q;
    assign cfg_error      = cfgErr_q;

endmodule

// File: tb/tb_stereo_frame_sequencer.sv
// tb_stereo_frame_sequencer
// Drives stereo_frame_sequencer with directed sequences followed by random
// traffic and compares every output each cycle against a byte-queue model of
// the sequencer. A narrow underrun counter is used so saturation is reached.

module tb_stereo_frame_sequencer;

    localparam int UW = 4;
    localparam int COUNT_MAX = (1 << UW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [3:0]    sample_size;
    logic          rxf_n;
    logic [7:0]    data_in;
    logic          rd_n;
    logic [31:0]   left_sample;
    logic [31:0]   right_sample;
    logic          frame_valid;
    logic          frame_ready;
    logic          underrun;
    logic [UW-1:0] underrun_count;
    logic          cfg_error;
    logic          busy;

    int testsRun    = 0;
    int testsFailed = 0;
    int pulseCount  = 0;

    // Reference model: a frame in progress is just the list of bytes popped
    // so far; it is complete once it holds two samples' worth of bytes.
    bit          mFetching;
    bit          mPending;
    bit          mValid;
    bit          mErr;
    int          mCode;
    logic [7:0]  mBytes[$];
    logic [31:0] mLeft;
    logic [31:0] mRight;
    int          mCount;

    stereo_frame_sequencer #(.UNDERRUN_W(UW)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .sample_size    (sample_size),
        .rxf_n          (rxf_n),
        .data_in        (data_in),
        .rd_n           (rd_n),
        .left_sample    (left_sample),
        .right_sample   (right_sample),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .cfg_error      (cfg_error),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int bytesPer(input int code);
        case (code)
            0:       return 1;
            4:       return 3;
            5:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] maskFor(input int code);
        case (code)
            0:       return 32'h0000_00FF;
            1:       return 32'h0000_0FFF;
            4:       return 32'h00FF_FFFF;
            5:       return 32'hFFFF_FFFF;
            default: return 32'h0000_FFFF;
        endcase
    endfunction

    function automatic bit isLegal(input int code);
        return (code == 0) || (code == 1) || (code == 3) || (code == 4) || (code == 5);
    endfunction

    // Little-endian value of the sample starting at byte 'first'.
    function automatic logic [31:0] assemble(input int first);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < bytesPer(mCode); i++)
            v = v + (32'(mBytes[first + i]) << (8 * i));
        return v & maskFor(mCode);
    endfunction

    task automatic modelReset();
        mFetching = 0;
        mPending  = 0;
        mValid    = 0;
        mErr      = 0;
        mCode     = 0;
        mBytes.delete();
        mLeft     = 32'd0;
        mRight    = 32'd0;
        mCount    = 0;
    endtask

    task automatic modelStart();
        mFetching = 1;
        mPending  = 0;
        mCode     = int'(sample_size);
        mErr      = !isLegal(mCode);
        mBytes.delete();
    endtask

    function automatic bit expUnderrun();
        return !rst && frame_ready && !mValid && (mFetching || mPending || enable);
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        bit          under;
        bit          load;
        logic [31:0] nl;
        logic [31:0] nr;
        if (rst) begin
            modelReset();
            return;
        end
        under = expUnderrun();
        load  = 0;
        nl    = 32'd0;
        nr    = 32'd0;
        if (mFetching) begin
            if (!rxf_n) begin
                mBytes.push_back(data_in);
                if (mBytes.size() == 2 * bytesPer(mCode)) begin
                    if (!mValid || frame_ready) load = 1;
                    else begin
                        mFetching = 0;
                        mPending  = 1;
                    end
                end
            end
        end else if (mPending) begin
            if (frame_ready) load = 1;
        end else if (enable) begin
            modelStart();
        end
        if (load) begin
            nl        = assemble(0);
            nr        = assemble(bytesPer(mCode));
            mFetching = 0;
            mPending  = 0;
            if (enable) modelStart();
            mValid = 1;
            mLeft  = nl;
            mRight = nr;
        end else if (frame_ready) begin
            mValid = 0;
        end
        if (under && mCount < COUNT_MAX) mCount++;
    endtask

    task automatic compareAll();
        checkOutput("rd_n", rd_n, !(mFetching && !rxf_n));
        checkOutput("busy", busy, mFetching || mPending);
        checkOutput("underrun", underrun, expUnderrun());
        checkOutput("frame_valid", frame_valid, mValid);
        checkOutput("left_sample", left_sample, mLeft);
        checkOutput("right_sample", right_sample, mRight);
        checkOutput("underrun_count", underrun_count, mCount);
        checkOutput("cfg_error", cfg_error, mErr);
    endtask

    // Drives one cycle of inputs, checks the DUT mid-cycle, then lets the
    // clock edge happen and steps the model to match.
    task automatic applyStimulus(input logic en, input logic [3:0] size, input logic rxfn,
                                 input logic [7:0] data, input logic ready, input logic r);
        enable      = en;
        sample_size = size;
        rxf_n       = rxfn;
        data_in     = data;
        frame_ready = ready;
        rst         = r;
        @(negedge clk);
        compareAll();
        if (underrun) pulseCount++;
        @(posedge clk);
        #1;
        modelStep();
    endtask

    task automatic drain();
        applyStimulus(1'b0, 4'd0, 1'b1, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        enable      = 1'b0;
        sample_size = 4'd0;
        rxf_n       = 1'b1;
        data_in     = 8'h00;
        frame_ready = 1'b0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        rst = 1'b0;

        // Reset state
        checkOutput("reset_rd_n", rd_n, 1);
        checkOutput("reset_valid", frame_valid, 0);
        checkOutput("reset_left", left_sample, 0);
        checkOutput("reset_right", right_sample, 0);
        checkOutput("reset_underrun", underrun, 0);
        checkOutput("reset_count", underrun_count, 0);
        checkOutput("reset_cfg_error", cfg_error, 0);
        checkOutput("reset_busy", busy, 0);

        // 16-bit frame at full rate, enable dropped so it ends in IDLE
        applyStimulus(1, 4'd3, 1, 8'h00, 0, 0);
        applyStimulus(0, 4'd3, 0, 8'h34, 0, 0);
        applyStimulus(0, 4'd3, 0, 8'h12, 0, 0);
        applyStimulus(0, 4'd3, 0, 8'h78, 0, 0);
        checkOutput("s16_valid_before", frame_valid, 0);
        applyStimulus(0, 4'd3, 0, 8'h56, 0, 0);
        checkOutput("s16_valid", frame_valid, 1);
        checkOutput("s16_left", left_sample, 32'h0000_1234);
        checkOutput("s16_right", right_sample, 32'h0000_5678);
        drain();

        // 24-bit, second frame has to wait for the holding register
        applyStimulus(1, 4'd4, 1, 8'h00, 0, 0);
        for (int i = 1; i <= 6; i++) applyStimulus(1, 4'd4, 0, 8'(i), 0, 0);
        checkOutput("s24_left1", left_sample, 32'h0003_0201);
        checkOutput("s24_right1", right_sample, 32'h0006_0504);
        for (int i = 1; i <= 6; i++) applyStimulus(1, 4'd4, 0, 8'(8'h10 + i), 0, 0);
        applyStimulus(1, 4'd4, 0, 8'h77, 0, 0);
        checkOutput("s24_wait_rd_n", rd_n, 1);
        checkOutput("s24_wait_busy", busy, 1);
        checkOutput("s24_wait_left", left_sample, 32'h0003_0201);
        applyStimulus(0, 4'd4, 1, 8'h00, 1, 0);
        checkOutput("s24_valid_kept", frame_valid, 1);
        checkOutput("s24_left2", left_sample, 32'h0013_1211);
        checkOutput("s24_right2", right_sample, 32'h0016_1514);
        drain();

        // 8-bit with the FIFO present only every other cycle
        applyStimulus(1, 4'd0, 1, 8'h00, 0, 0);
        applyStimulus(0, 4'd0, 1, 8'h55, 0, 0);
        applyStimulus(0, 4'd0, 0, 8'hAA, 0, 0);
        applyStimulus(0, 4'd0, 1, 8'h66, 0, 0);
        applyStimulus(0, 4'd0, 0, 8'hBB, 0, 0);
        checkOutput("s8_left", left_sample, 32'h0000_00AA);
        checkOutput("s8_right", right_sample, 32'h0000_00BB);
        drain();

        // Illegal code behaves as 16-bit; a size change mid-frame waits
        applyStimulus(1, 4'd2, 1, 8'h00, 0, 0);
        checkOutput("illegal_cfg_error", cfg_error, 1);
        applyStimulus(1, 4'd2, 0, 8'hFF, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 4'd5, 0, 8'hFF, 0, 0);
        checkOutput("illegal_left", left_sample, 32'h0000_FFFF);
        checkOutput("illegal_right", right_sample, 32'h0000_FFFF);
        checkOutput("relatch_cfg_error", cfg_error, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 4'd5, 0, 8'(8'h10 + i), 0, 0);
        applyStimulus(0, 4'd5, 1, 8'h00, 1, 0);
        checkOutput("s32_left", left_sample, 32'h1312_1110);
        checkOutput("s32_right", right_sample, 32'h1716_1514);
        drain();

        // Underruns counted from a clean reset, then saturation
        applyStimulus(0, 4'd0, 1, 8'h00, 0, 1);
        pulseCount = 0;
        for (int i = 0; i < 5; i++) applyStimulus(1, 4'd3, 1, 8'h00, 1, 0);
        checkOutput("underrun_pulses", pulseCount, 5);
        checkOutput("underrun_count5", underrun_count, 5);
        for (int i = 0; i < 12; i++) applyStimulus(1, 4'd3, 1, 8'h00, 1, 0);
        checkOutput("underrun_saturate", underrun_count, COUNT_MAX);

        // Reset in the middle of a frame throws the partial frame away
        applyStimulus(1, 4'd3, 0, 8'hE1, 0, 0);
        applyStimulus(1, 4'd3, 0, 8'hE2, 0, 0);
        applyStimulus(1, 4'd3, 1, 8'h00, 0, 1);
        checkOutput("midrst_count", underrun_count, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_rd_n", rd_n, 1);
        applyStimulus(1, 4'd3, 1, 8'h00, 0, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(0, 4'd3, 0, 8'(i), 0, 0);
        checkOutput("midrst_left", left_sample, 32'h0000_0201);
        checkOutput("midrst_right", right_sample, 32'h0000_0403);
        drain();

        // Enable dropped after the first byte: frame still delivered, then idle
        applyStimulus(1, 4'd0, 1, 8'h00, 0, 0);
        applyStimulus(0, 4'd0, 0, 8'h5A, 0, 0);
        applyStimulus(0, 4'd0, 0, 8'hA5, 0, 0);
        applyStimulus(0, 4'd0, 0, 8'hC3, 0, 0);
        checkOutput("endrop_busy", busy, 0);
        checkOutput("endrop_rd_n", rd_n, 1);
        checkOutput("endrop_left", left_sample, 32'h0000_005A);
        checkOutput("endrop_right", right_sample, 32'h0000_00A5);
        drain();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(7) != 0),
                          ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(5)),
                          1'($urandom_range(1)),
                          8'($urandom),
                          1'($urandom_range(1)),
                          ($urandom_range(299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
